omr_sheet_loader: RTL and testbench

//  Producer side of the grader's student_answers bus. Accepts one question's 4-bubble

---
 rtl/omr_sheet_loader.sv | 175 +++++++++++++++++
 tb/tb_omr_sheet_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/omr_sheet_loader.sv
// ---------------------------------------------------------------------------
// omr_sheet_loader
//   Producer side of the grader's student_answers bus. Accepts one question's
//   bubble scan per valid/ready beat and assembles a NUM_Q*ANS_W answer word.
//   The finished word goes to the grader with a valid/ack handshake.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   async, active-high
//   start           in   begin a new sheet (1-cycle pulse)
//   bubble_valid    in   scanner beat valid
//   bubble_data     in   [ANS_W-1:0] bubbles for the current question
//   bubble_ready    out  loader accepts a beat (LOAD only)
//   student_answers out  [NUM_Q*ANS_W-1:0]; question k at [k*ANS_W +: ANS_W]
//   invalid_mask    out  [NUM_Q-1:0]; bit k = question k was not one-hot
//   sheet_valid     out  sheet complete and held stable (HOLD only)
//   sheet_ack       in   grader consumed the sheet
//   q_index         out  [CW-1:0] next question slot to fill
//   busy            out  state != IDLE
//
// Build option
//   ONEHOT_CHECK_EN : when defined, non-one-hot beats are stored as 0 and
//                     flagged in invalid_mask. When undefined, beats are
//                     stored raw and invalid_mask stays 0.
// ---------------------------------------------------------------------------

// One answer slot: holds a single question's bubbles plus its invalid flag.
module omr_slot #(
  parameter int ANS_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [ANS_W-1:0] data_i,
  output logic [ANS_W-1:0] ans_o,
  output logic             inv_o
);
  logic [ANS_W-1:0] ans_q, ans_d;
  logic             inv_q, inv_d;
  logic [ANS_W-1:0] store;
  logic             bad;

`ifdef ONEHOT_CHECK_EN
  logic onehot;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
  assign onehot = (data_i != '0) && ((data_i & (data_i - 1'b1)) == '0);
  // A zero slot can never match a one-hot answer key.
  assign store  = onehot ? data_i : '0;
  assign bad    = ~onehot;
`else
  assign store  = data_i;
  assign bad    = 1'b0;
`endif

  always_comb begin
    ans_d = ans_q;
    inv_d = inv_q;
    if (clr_i) begin
      ans_d = '0;
      inv_d = 1'b0;
    end else if (wr_i) begin
      ans_d = store;
      inv_d = bad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ans_q <= '0;
      inv_q <= 1'b0;
    end else begin
      ans_q <= ans_d;
      inv_q <= inv_d;
    end
  end

  assign ans_o = ans_q;
  assign inv_o = inv_q;
endmodule

module omr_sheet_loader #(
  parameter int NUM_Q = 10,
  parameter int ANS_W = 4,
  parameter int CW    = $clog2(NUM_Q + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   bubble_valid,
  input  logic [ANS_W-1:0]       bubble_data,
  output logic                   bubble_ready,
  output logic [NUM_Q*ANS_W-1:0] student_answers,
  output logic [NUM_Q-1:0]       invalid_mask,
  output logic                   sheet_valid,
  input  logic                   sheet_ack,
  output logic [CW-1:0]          q_index,
  output logic                   busy
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  localparam int unsigned   LAST_I = NUM_Q - 1;
  localparam logic [CW-1:0] LAST   = LAST_I[CW-1:0];

  state_t                          state_q, state_d;
  logic   [CW-1:0]                 q_index_q, q_index_d;
  logic                            beat, clr, wr_en;
  logic   [NUM_Q-1:0][ANS_W-1:0]   slot_ans;
  logic   [NUM_Q-1:0]              slot_inv;

  assign beat  = bubble_valid & (state_q == S_LOAD);
  // start clears the sheet from IDLE or LOAD; in HOLD it is ignored.
  assign clr   = start & ((state_q == S_IDLE) | (state_q == S_LOAD));
  // A restart wins over a coincident beat: the beat is dropped.
  assign wr_en = beat & ~start;

  always_comb begin
    state_d   = state_q;
    q_index_d = q_index_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          q_index_d = '0;
        end
      end
      S_LOAD: begin
        if (start) begin
          q_index_d = '0;
        end else if (beat) begin
          q_index_d = q_index_q + 1'b1;
          if (q_index_q == LAST) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // ack wins over a coincident start; the start is lost.
        if (sheet_ack) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        q_index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      q_index_q <= '0;
    end else begin
      state_q   <= state_d;
      q_index_q <= q_index_d;
    end
  end

  for (genvar k = 0; k < NUM_Q; k++) begin : g_slot
    localparam logic [CW-1:0] KIDX = CW'(k);
    omr_slot #(.ANS_W(ANS_W)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (clr),
      .wr_i   (wr_en & (q_index_q == KIDX)),
      .data_i (bubble_data),
      .ans_o  (slot_ans[k]),
      .inv_o  (slot_inv[k])
    );
  end

  assign student_answers = slot_ans;
  assign invalid_mask    = slot_inv;
  assign q_index         = q_index_q;
  assign bubble_ready    = (state_q == S_LOAD);
  assign sheet_valid     = (state_q == S_HOLD);
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_omr_sheet_loader.sv
module tb_omr_sheet_loader;
  localparam int NUM_Q = 10;
  localparam int ANS_W = 4;
  localparam int CW    = 4;

  logic                   clk = 1'b0;
  logic                   reset, start, bubble_valid, sheet_ack;
  logic [ANS_W-1:0]       bubble_data;
  logic                   bubble_ready, sheet_valid, busy;
  logic [NUM_Q*ANS_W-1:0] student_answers;
  logic [NUM_Q-1:0]       invalid_mask;
  logic [CW-1:0]          q_index;

  omr_sheet_loader #(.NUM_Q(NUM_Q), .ANS_W(ANS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .bubble_valid(bubble_valid),
    .bubble_data(bubble_data), .bubble_ready(bubble_ready),
    .student_answers(student_answers), .invalid_mask(invalid_mask),
    .sheet_valid(sheet_valid), .sheet_ack(sheet_ack), .q_index(q_index),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sheet phase (0 idle, 1 loading, 2 holding) plus answer array.
  int         m_mode;
  logic [3:0] m_ans [NUM_Q];
  logic       m_inv [NUM_Q];
  int         m_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_Q*ANS_W-1:0] exp_answers();
    logic [NUM_Q*ANS_W-1:0] w = '0;
    for (int i = 0; i < NUM_Q; i++) w = w | ({36'd0, m_ans[i]} << (i * ANS_W));
    return w;
  endfunction

  function automatic logic [NUM_Q-1:0] exp_mask();
    logic [NUM_Q-1:0] w = '0;
    for (int i = 0; i < NUM_Q; i++) if (m_inv[i]) w = w | (10'd1 << i);
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_Q; i++) begin m_ans[i] = 4'h0; m_inv[i] = 1'b0; end
    m_q = 0;
  endtask

  task automatic model_store(input logic [3:0] d);
`ifdef ONEHOT_CHECK_EN
    if ($countones(d) == 1) m_ans[m_q] = d;
    else begin m_ans[m_q] = 4'h0; m_inv[m_q] = 1'b1; end
`else
    m_ans[m_q] = d;
`endif
    m_q = m_q + 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".answers"}, 64'(student_answers), 64'(exp_answers()));
    chk({tag, ".mask"},    64'(invalid_mask),    64'(exp_mask()));
    chk({tag, ".q_index"}, 64'(q_index),         64'(m_q));
    chk({tag, ".valid"},   64'(sheet_valid),     64'(m_mode == 2));
    chk({tag, ".ready"},   64'(bubble_ready),    64'(m_mode == 1));
    chk({tag, ".busy"},    64'(busy),            64'(m_mode != 0));
  endtask

  // One clock cycle: drive on the falling edge, update model, check after the rising edge.
  task automatic step(input string tag, input logic s, input logic v,
                      input logic [3:0] d, input logic a);
    @(negedge clk);
    start = s; bubble_valid = v; bubble_data = d; sheet_ack = a;
    @(posedge clk);
    case (m_mode)
      0: if (s) begin model_clear(); m_mode = 1; end
      1: if (s) model_clear();
         else if (v) begin
           model_store(d);
           if (m_q == NUM_Q) m_mode = 2;
         end
      default: if (a) m_mode = 0;
    endcase
    #1 check_all(tag);
  endtask

  function automatic logic [3:0] rnd_onehot();
    return 4'(4'h1 << $urandom_range(0, 3));
  endfunction

  initial begin
    logic [3:0] pat [10];
    int         cyc;
    pat = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    reset = 1'b1; start = 1'b0; bubble_valid = 1'b0; bubble_data = 4'h0; sheet_ack = 1'b0;
    m_mode = 0; model_clear();
    #2 check_all("reset");
    @(negedge clk) reset = 1'b0;

    // T1: async reset mid-load after 3 beats
    step("t1.start", 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("t1.beat", 1'b0, 1'b1, 4'h4, 1'b0);
    #2 reset = 1'b1;
    m_mode = 0; model_clear();
    #1 check_all("t1.async");
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) step("t1.idle", 1'b0, 1'b1, 4'h2, 1'b1);

    // T2: back-to-back beats
    step("t2.start", 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < NUM_Q; i++) step("t2.beat", 1'b0, 1'b1, pat[i], 1'b0);
    chk("t2.word", 64'(student_answers), 64'h2184218421);
    chk("t2.qidx", 64'(q_index), 64'd10);
    chk("t2.sv",   64'(sheet_valid), 64'd1);
    step("t2.ack", 1'b0, 1'b0, 4'h0, 1'b1);
    chk("t2.sv_clr", 64'(sheet_valid), 64'd0);

    // T3: toggling valid
    step("t3.start", 1'b1, 1'b0, 4'h0, 1'b0);
    cyc = 0;
    while (m_mode == 1 && cyc < 40) begin
      step("t3.tog", 1'b0, cyc[0] == 1'b0, rnd_onehot(), 1'b0);
      cyc++;
    end
    chk("t3.done", 64'(sheet_valid), 64'd1);
    step("t3.ack", 1'b0, 1'b0, 4'h0, 1'b1);

    // T4: restart after 5 beats; the coincident beat is dropped
    step("t4.start", 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) step("t4.beat", 1'b0, 1'b1, 4'h8, 1'b0);
    step("t4.restart", 1'b1, 1'b1, 4'h8, 1'b0);
    chk("t4.q0",    64'(q_index), 64'd0);
    chk("t4.clear", 64'(student_answers), 64'd0);
    for (int i = 0; i < NUM_Q; i++) step("t4.beat2", 1'b0, 1'b1, 4'h1, 1'b0);
    chk("t4.word", 64'(student_answers), 64'h1111111111);
    step("t4.ack", 1'b0, 1'b0, 4'h0, 1'b1);

    // T5: invalid patterns at Q2 and Q7
    step("t5.start", 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < NUM_Q; i++)
      step("t5.beat", 1'b0, 1'b1, (i == 2) ? 4'h6 : (i == 7) ? 4'h0 : pat[i], 1'b0);
`ifdef ONEHOT_CHECK_EN
    chk("t5.mask",  64'(invalid_mask), 64'h084);
    chk("t5.slot2", 64'(student_answers[11:8]), 64'h0);
`else
    chk("t5.mask",  64'(invalid_mask), 64'h000);
    chk("t5.slot2", 64'(student_answers[11:8]), 64'h6);
`endif
    chk("t5.slot7", 64'(student_answers[31:28]), 64'h0);

    // T6: hold with late ack, scanner still pushing; start in HOLD ignored
    for (int i = 0; i < 5; i++) step("t6.hold", i == 2, 1'b1, 4'($urandom), 1'b0);
    chk("t6.stable", 64'(student_answers), 64'(exp_answers()));
    step("t6.ack_start", 1'b1, 1'b1, 4'h8, 1'b1);
    chk("t6.idle", 64'(busy), 64'd0);
    step("t6.ack_out", 1'b0, 1'b0, 4'h0, 1'b1);

    // Random traffic: restarts, idle gaps, stray acks, invalid patterns
    for (int i = 0; i < 800; i++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : rnd_onehot();
      step("rand", $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, d,
           $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
